// File: rtl/ex_lsu.sv
// ex_lsu: load/store execution unit. Accepts one memory instruction at a
// time, computes the effective address, runs a single-port bus access with
// byte strobes and lane-aligned data, and returns extended load data or a
// one-cycle exception pulse.
//
// state  | meaning
// IDLE   | ready for a new instruction
// READ   | load request on the bus, waiting for mem_rready
// WRITE  | store request on the bus, waiting for mem_wready
// RESP   | one cycle carrying the wb_valid or exc_valid pulse
module ex_lsu #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [11:0]       req_imm,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rready,
    input  logic              mem_wready,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_pending,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [XLEN-1:0]   exc_addr
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Expiry is flagged on the edge where the counter already holds
    // TIMEOUT_CYC-1, so the enable stays high for exactly TIMEOUT_CYC cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] ea_q;
    logic [CW-1:0]   cnt;

    logic [XLEN-1:0] ea;
    logic [OW-1:0]   off;
    logic            illegal;
    logic            misaligned;
    logic [7:0]      mask8;
    logic [NB-1:0]   strb;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rdata_sh;
    logic [XLEN-1:0] ld_data;
    logic            timeout_hit;

    // Request decode: effective address, legality, lane strobes and data.
    always_comb begin
        ea         = req_rs1 + XLEN'($signed(req_imm));
        off        = ea[OW-1:0];
        illegal    = (req_funct3 == 3'b111)
                   | ((XLEN == 32) & ((req_funct3 == 3'b011) | (req_funct3 == 3'b110)))
                   | (req_store & req_funct3[2]);
        misaligned = 1'b0;
        mask8      = 8'h01;
        case (req_funct3[1:0])
            2'b01: begin misaligned = ea[0];      mask8 = 8'h03; end
            2'b10: begin misaligned = |ea[1:0];   mask8 = 8'h0F; end
            2'b11: begin misaligned = |ea[2:0];   mask8 = 8'hFF; end
            default: begin misaligned = 1'b0;     mask8 = 8'h01; end
        endcase
        strb     = NB'(mask8) << off;
        wdata_sh = req_rs2 << {off, 3'b000};
    end

    // Load data alignment and sign/zero extension from the registered offset.
    always_comb begin
        rdata_sh = mem_rdata >> {ea_q[OW-1:0], 3'b000};
        ld_data  = rdata_sh;
        case (f3_q[1:0])
            2'b00: begin
                if (f3_q[2]) ld_data = XLEN'(rdata_sh[7:0]);
                else         ld_data = XLEN'($signed(rdata_sh[7:0]));
            end
            2'b01: begin
                if (f3_q[2]) ld_data = XLEN'(rdata_sh[15:0]);
                else         ld_data = XLEN'($signed(rdata_sh[15:0]));
            end
            2'b10: begin
                if (f3_q[2]) ld_data = XLEN'(rdata_sh[31:0]);
                else         ld_data = XLEN'($signed(rdata_sh[31:0]));
            end
            default: ld_data = rdata_sh;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
    assign req_ready   = (state == S_IDLE);
    assign wb_pending  = (state == S_READ)
                       | ((state == S_IDLE) & req_valid & ~req_store)
                       | ((state == S_RESP) & wb_valid);

    // Main sequencer: accept, bus wait with timeout, one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_q      <= '0;
            f3_q      <= '0;
            ea_q      <= '0;
            cnt       <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_cause <= '0;
            exc_addr  <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rd_q <= req_rd;
                        f3_q <= req_funct3;
                        ea_q <= ea;
                        cnt  <= '0;
                        if (illegal) begin
                            exc_valid <= 1'b1;
                            exc_cause <= 2'd3;
                            exc_addr  <= ea;
                            state     <= S_RESP;
                        end else if (misaligned) begin
                            exc_valid <= 1'b1;
                            exc_cause <= {1'b0, req_store};
                            exc_addr  <= ea;
                            state     <= S_RESP;
                        end else begin
                            mem_addr  <= {ea[XLEN-1:OW], {OW{1'b0}}};
                            mem_wstrb <= strb;
                            if (req_store) begin
                                mem_wr_en <= 1'b1;
                                mem_wdata <= wdata_sh;
                                state     <= S_WRITE;
                            end else begin
                                mem_rd_en <= 1'b1;
                                state     <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (mem_rready) begin
                        mem_rd_en <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_data   <= ld_data;
                        wb_rd     <= rd_q;
                        state     <= S_RESP;
                    end else if (timeout_hit) begin
                        mem_rd_en <= 1'b0;
                        exc_valid <= 1'b1;
                        exc_cause <= 2'd2;
                        exc_addr  <= ea_q;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WRITE: begin
                    if (mem_wready) begin
                        mem_wr_en <= 1'b0;
                        state     <= S_RESP;
                    end else if (timeout_hit) begin
                        mem_wr_en <= 1'b0;
                        exc_valid <= 1'b1;
                        exc_cause <= 2'd2;
                        exc_addr  <= ea_q;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_lsu.sv
// tb_ex_lsu: drives a 32-bit (timeout 4) and a 64-bit (timeout 6) ex_lsu
// with the same instruction stream and compares both cycle by cycle
// against an arithmetic reference model.
module tb_ex_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic [63:0] req_rs1, req_rs2, mem_rdata;
    logic [11:0] req_imm;
    logic        mem_rready, mem_wready;

    logic        rdy32, rden32, wren32, wbv32, pend32, excv32;
    logic [31:0] addr32, wdata32, wbd32, exca32;
    logic [3:0]  strb32;
    logic [4:0]  wbrd32;
    logic [1:0]  cause32;

    logic        rdy64, rden64, wren64, wbv64, pend64, excv64;
    logic [63:0] addr64, wdata64, wbd64, exca64;
    logic [7:0]  strb64;
    logic [4:0]  wbrd64;
    logic [1:0]  cause64;

    logic [63:0] o_addr[2], o_wdata[2], o_wbd[2], o_exca[2];
    logic [7:0]  o_strb[2];
    logic        o_rdy[2], o_rden[2], o_wren[2], o_wbv[2], o_pend[2], o_excv[2];
    logic [4:0]  o_wbrd[2];
    logic [1:0]  o_cause[2];

    int vecs = 0;
    int errs = 0;
    logic [63:0] last_wb[2], last_exca[2];
    logic [4:0]  last_rd[2];

    typedef struct packed {
        logic        exc;
        logic [1:0]  cause;
        logic        bus;
        logic [63:0] ea;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] wbd;
        logic [7:0]  strb;
    } exp_t;

    always #5 clk = ~clk;

    ex_lsu #(.XLEN(32), .TIMEOUT_CYC(4)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy32),
        .req_store(req_store), .req_funct3(req_funct3), .req_rd(req_rd),
        .req_rs1(req_rs1[31:0]), .req_rs2(req_rs2[31:0]), .req_imm(req_imm),
        .mem_rd_en(rden32), .mem_wr_en(wren32), .mem_addr(addr32),
        .mem_wstrb(strb32), .mem_wdata(wdata32), .mem_rdata(mem_rdata[31:0]),
        .mem_rready(mem_rready), .mem_wready(mem_wready), .wb_valid(wbv32),
        .wb_rd(wbrd32), .wb_data(wbd32), .wb_pending(pend32),
        .exc_valid(excv32), .exc_cause(cause32), .exc_addr(exca32)
    );

    ex_lsu #(.XLEN(64), .TIMEOUT_CYC(6)) u64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy64),
        .req_store(req_store), .req_funct3(req_funct3), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .mem_rd_en(rden64), .mem_wr_en(wren64), .mem_addr(addr64),
        .mem_wstrb(strb64), .mem_wdata(wdata64), .mem_rdata(mem_rdata),
        .mem_rready(mem_rready), .mem_wready(mem_wready), .wb_valid(wbv64),
        .wb_rd(wbrd64), .wb_data(wbd64), .wb_pending(pend64),
        .exc_valid(excv64), .exc_cause(cause64), .exc_addr(exca64)
    );

    // Gather both instances' outputs into indexable arrays.
    always_comb begin
        o_addr[0] = {32'h0, addr32};   o_addr[1] = addr64;
        o_wdata[0] = {32'h0, wdata32}; o_wdata[1] = wdata64;
        o_wbd[0] = {32'h0, wbd32};     o_wbd[1] = wbd64;
        o_exca[0] = {32'h0, exca32};   o_exca[1] = exca64;
        o_strb[0] = {4'h0, strb32};    o_strb[1] = strb64;
        o_rdy[0] = rdy32;   o_rdy[1] = rdy64;
        o_rden[0] = rden32; o_rden[1] = rden64;
        o_wren[0] = wren32; o_wren[1] = wren64;
        o_wbv[0] = wbv32;   o_wbv[1] = wbv64;
        o_pend[0] = pend32; o_pend[1] = pend64;
        o_excv[0] = excv32; o_excv[1] = excv64;
        o_wbrd[0] = wbrd32; o_wbrd[1] = wbrd64;
        o_cause[0] = cause32; o_cause[1] = cause64;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tmo(int i);
        return (i == 0) ? 4 : 6;
    endfunction

    // Reference model: plain arithmetic on the architectural rules.
    function automatic exp_t model(int xl, logic st, logic [2:0] f3, logic [63:0] rs1,
                                   logic [11:0] imm, logic [63:0] rs2, logic [63:0] rdat);
        exp_t r;
        longint unsigned nb, off, sz;
        logic [127:0] full, msk, v;
        r = '0;
        full = (xl == 64) ? {64'h0, {64{1'b1}}} : 128'hFFFF_FFFF;
        r.ea = (rs1 + {{52{imm[11]}}, imm}) & full[63:0];
        nb = longint'(xl / 8);
        off = r.ea % nb;
        sz = longint'(1) << f3[1:0];
        r.addr = r.ea - off;
        if (f3 == 3'd7 || (xl == 32 && (f3 == 3'd3 || f3 == 3'd6)) || (st && f3 >= 3'd4)) begin
            r.exc = 1'b1; r.cause = 2'd3;
        end else if (r.ea % sz != 0) begin
            r.exc = 1'b1; r.cause = st ? 2'd1 : 2'd0;
        end else begin
            r.bus = 1'b1;
        end
        r.strb = 8'(((longint'(1) << sz) - 1) << off);
        r.wdata = 64'((128'(rs2) << (8 * off)) & full);
        v = 128'(rdat & full[63:0]) >> (8 * off);
        msk = (128'(1) << (8 * sz)) - 128'(1);
        v = v & msk;
        if (!f3[2] && v[8*sz-1]) v = v | ~msk;
        r.wbd = 64'(v & full);
        return r;
    endfunction

    // Issue one instruction to both units; ready is pulsed at edge d after
    // accept (d=0: never).
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [63:0] rs1,
                          input logic [11:0] imm, input logic [63:0] rs2,
                          input logic [63:0] rdat, input int d);
        exp_t e[2];
        int   ee[2];
        logic wbp[2], excp[2];
        logic [1:0] ec[2];
        int   last_n;
        logic [4:0] rd;
        rd = 5'($urandom);
        e[0] = model(32, st, f3, rs1, imm, rs2, rdat);
        e[1] = model(64, st, f3, rs1, imm, rs2, rdat);
        for (int i = 0; i < 2; i++) begin
            wbp[i] = 1'b0; excp[i] = 1'b0; ec[i] = e[i].cause;
            if (e[i].exc) begin
                ee[i] = 0; excp[i] = 1'b1;
            end else if (d >= 1 && d <= tmo(i)) begin
                ee[i] = d; wbp[i] = !st;
            end else begin
                ee[i] = tmo(i); excp[i] = 1'b1; ec[i] = 2'd2;
            end
        end
        last_n = ((ee[0] > ee[1]) ? ee[0] : ee[1]) + 1;

        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_rd = rd;
        req_rs1 = rs1; req_imm = imm; req_rs2 = rs2; mem_rdata = rdat;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pend_pre[%0d]", i), 64'(o_pend[i]), 64'(!st));
            check($sformatf("rdy_pre[%0d]", i), 64'(o_rdy[i]), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_rs1 = {$urandom, $urandom};
        req_rs2 = {$urandom, $urandom};
        for (int n = 0; n <= last_n; n++) begin
            mem_rready = !st && (n == d - 1);
            mem_wready = st && (n == d - 1);
            for (int i = 0; i < 2; i++) begin
                logic busy, wpul, xpul;
                busy = e[i].bus && (n < ee[i]);
                wpul = wbp[i] && (n == ee[i]);
                xpul = excp[i] && (n == ee[i]);
                if (wpul) begin last_wb[i] = e[i].wbd; last_rd[i] = rd; end
                if (xpul) last_exca[i] = e[i].ea;
                check($sformatf("rd_en[%0d] n%0d", i, n), 64'(o_rden[i]), 64'(busy && !st));
                check($sformatf("wr_en[%0d] n%0d", i, n), 64'(o_wren[i]), 64'(busy && st));
                if (busy) begin
                    check($sformatf("addr[%0d]", i), o_addr[i], e[i].addr);
                    check($sformatf("wstrb[%0d]", i), 64'(o_strb[i]), 64'(e[i].strb));
                    if (st) check($sformatf("wdata[%0d]", i), o_wdata[i], e[i].wdata);
                end
                check($sformatf("wb_valid[%0d] n%0d", i, n), 64'(o_wbv[i]), 64'(wpul));
                check($sformatf("exc_valid[%0d] n%0d", i, n), 64'(o_excv[i]), 64'(xpul));
                if (xpul) check($sformatf("exc_cause[%0d]", i), 64'(o_cause[i]), 64'(ec[i]));
                check($sformatf("wb_data[%0d]", i), o_wbd[i], last_wb[i]);
                check($sformatf("wb_rd[%0d]", i), 64'(o_wbrd[i]), 64'(last_rd[i]));
                check($sformatf("exc_addr[%0d]", i), o_exca[i], last_exca[i]);
                check($sformatf("req_ready[%0d] n%0d", i, n), 64'(o_rdy[i]), 64'(n > ee[i]));
                check($sformatf("wb_pending[%0d] n%0d", i, n), 64'(o_pend[i]),
                      64'((busy && !st) || wpul));
            end
            if (n < last_n) @(negedge clk);
        end
        mem_rready = 1'b0;
        mem_wready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_rd = '0;
        req_rs1 = '0; req_rs2 = '0; req_imm = '0; mem_rdata = '0;
        mem_rready = 1'b0; mem_wready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_wb[i] = '0; last_exca[i] = '0; last_rd[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_rdy[%0d]", i), 64'(o_rdy[i]), 64'd1);
            check($sformatf("rst_en[%0d]", i), 64'({o_rden[i], o_wren[i], o_wbv[i], o_excv[i], o_pend[i]}), 64'd0);
            check($sformatf("rst_bus[%0d]", i), o_addr[i] | o_wdata[i] | 64'(o_strb[i]), 64'd0);
            check($sformatf("rst_wb[%0d]", i), o_wbd[i] | o_exca[i] | 64'(o_wbrd[i]) | 64'(o_cause[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // LB / LBU at ea 0xFF
        do_txn(1'b0, 3'b000, 64'h100, 12'hFFF, 64'h0, 64'h80AABBCC, 2);
        check("lb_sext", o_wbd[0], 64'hFFFFFF80);
        do_txn(1'b0, 3'b100, 64'h100, 12'hFFF, 64'h0, 64'h80AABBCC, 1);
        check("lbu_zext", o_wbd[0], 64'h00000080);
        // SH to lane 2, ready after 3 cycles
        do_txn(1'b1, 3'b001, 64'h202, 12'h000, 64'h1234ABCD, 64'h0, 3);
        // LW misaligned
        do_txn(1'b0, 3'b010, 64'h102, 12'h000, 64'h0, 64'h0, 2);
        check("lw_mis_addr", o_exca[0], 64'h102);
        // SW timeout, then ready on the expiry edge
        do_txn(1'b1, 3'b010, 64'h300, 12'h004, 64'hDEADBEEF, 64'h0, 0);
        do_txn(1'b1, 3'b010, 64'h300, 12'h004, 64'hDEADBEEF, 64'h0, 4);
        do_txn(1'b0, 3'b010, 64'h300, 12'h000, 64'h0, 64'h0, 5);
        // LWU / LW at ea 0x1004
        do_txn(1'b0, 3'b110, 64'h1000, 12'h004, 64'h0, 64'h80000001_00000000, 2);
        check("lwu_64", o_wbd[1], 64'h0000000080000001);
        do_txn(1'b0, 3'b010, 64'h1000, 12'h004, 64'h0, 64'h80000001_00000000, 1);
        check("lw_64", o_wbd[1], 64'hFFFFFFFF80000001);
        // LD: illegal width at XLEN=32, legal at 64
        do_txn(1'b0, 3'b011, 64'h2000, 12'h008, 64'h0, 64'h8877665544332211, 2);
        check("ld_cause32", 64'(o_cause[0]), 64'd3);
        // SB as store with unsigned width code -> illegal
        do_txn(1'b1, 3'b100, 64'h40, 12'h001, 64'h55, 64'h0, 1);

        for (int k = 0; k < 160; k++) begin
            logic [63:0] rs1;
            logic [11:0] imm;
            rs1 = {$urandom, $urandom};
            imm = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rs1[2:0] = '0;
                imm[2:0] = 3'($urandom_range(0, 1) * 4);
            end
            do_txn(1'($urandom), 3'($urandom), rs1, imm, {$urandom, $urandom},
                   {$urandom, $urandom}, int'($urandom_range(0, 8)));
        end

        // Reset in the middle of a load
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_rs1 = 64'h200; req_imm = 12'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mid_rst_rden[%0d]", i), 64'(o_rden[i]), 64'd0);
            check($sformatf("mid_rst_rdy[%0d]", i), 64'(o_rdy[i]), 64'd1);
            check($sformatf("mid_rst_wbv[%0d]", i), 64'(o_wbv[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_rready = 1'b1;
        mem_wready = 1'b1;
        @(negedge clk);
        mem_rready = 1'b0;
        mem_wready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("post_rst_wbv[%0d]", i), 64'(o_wbv[i]), 64'd0);
            check($sformatf("post_rst_excv[%0d]", i), 64'(o_excv[i]), 64'd0);
            check($sformatf("post_rst_rdy[%0d]", i), 64'(o_rdy[i]), 64'd1);
            last_wb[i] = '0; last_exca[i] = '0; last_rd[i] = '0;
        end
        do_txn(1'b0, 3'b001, 64'h10, 12'h002, 64'h0, 64'hFFFF_8001_0000, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
